mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared single-port word data memory in the multi-cycle core.
- Requester 0 is the core load/store path; requester 1 is the debug/DMA loader.
- Accepts one request at a time and registers it. Drives the memory for one ACCESS cycle, then returns an ack with registered read data.
- Round-robin fairness when both requesters are pending.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter and sequencer for two requesters sharing one single-port word memory.
// Latency: request sampled in IDLE -> ACCESS next cycle -> ack with registered read data the cycle after (2 cycles).
// Backpressure: a requester holds req and its qualifiers until its one-cycle ack; the others wait for arbitration.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req/we/adr/wdata (0 and 1)    requester command; 0 = core load/store, 1 = debug/DMA loader
//   ack/rdata (0 and 1)           completion pulse, with read data valid while ack is high
//   mem_adr/mem_wdata/mem_we      word-aligned memory command, driven from the hold registers
//   mem_rdata                     combinational memory read data
//   busy                          high while a transfer is in ACCESS or RESP
module mem_arbiter #(
    parameter int N  = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [N-1:0]  wdata0,
    output logic          ack0,
    output logic [N-1:0]  rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [N-1:0]  wdata1,
    output logic          ack1,
    output logic [N-1:0]  rdata1,

    output logic [AW-1:0] mem_adr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Command captured at grant; only the word part of the address is kept.
    logic [AW-3:0]   hold_word;
    logic [N-1:0]    hold_wdata;
    logic            hold_we;
    logic            owner;      // port currently being served
    logic            last;       // port granted most recently (tie-breaker)

    logic            elig0;
    logic            elig1;
    logic            grant_vld;
    logic            grant_port;

    // Byte offset within the word is intentionally dropped: misaligned
    // addresses simply hit the containing word.
    logic            unused_byte_ofs;
    assign unused_byte_ofs = ^{adr0[1:0], adr1[1:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration, next state and acknowledge outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        elig0      = 1'b0;
        elig1      = 1'b0;
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;

        case (state)
            IDLE, RESP: begin
                // In RESP the owner's req is still high for the ack cycle;
                // it must not be mistaken for a fresh request.
                elig0 = req0 & ~((state == RESP) & (owner == 1'b0));
                elig1 = req1 & ~((state == RESP) & (owner == 1'b1));

                grant_vld  = elig0 | elig1;
                // Tie goes to the port that was not served last.
                grant_port = (elig0 & elig1) ? ~last : elig1;

                if (state == RESP) begin
                    ack0 = (owner == 1'b0);
                    ack1 = (owner == 1'b1);
                end

                state_nxt = grant_vld ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hold registers, round-robin pointer and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word  <= '0;
            hold_wdata <= '0;
            hold_we    <= 1'b0;
            owner      <= 1'b0;
            last       <= 1'b1;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (grant_vld) begin
                hold_word  <= grant_port ? adr1[AW-1:2] : adr0[AW-1:2];
                hold_wdata <= grant_port ? wdata1 : wdata0;
                hold_we    <= grant_port ? we1 : we0;
                owner      <= grant_port;
                last       <= grant_port;
            end

            // Read data is registered at the end of ACCESS so the ack cycle
            // presents a stable value; the non-owner keeps its old data.
            if ((state == ACCESS) && !hold_we) begin
                if (owner) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    assign mem_adr   = {hold_word, 2'b00};
    assign mem_wdata = hold_wdata;
    // Gating with rst keeps a write from committing on a reset edge.
    assign mem_we    = (state == ACCESS) & hold_we & ~rst;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed cycle table, a tie sequence, and
// randomized traffic checked against a transaction-level memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wdata0, adr1, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        busy;

    mem_arbiter #(.N(32), .AW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .adr0     (adr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .adr1     (adr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .mem_adr  (mem_adr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple 256-word memory behind the arbiter.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_adr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[9:2]] = mem_wdata;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_ok(input string nm, input logic ok, input int act, input int lo, input int hi);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        e_ack0;
        logic        e_ack1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [31:0] e_madr;
        logic        e_mwe;
        logic        e_busy;
    } vec_t;

    localparam int NV = 25;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h12345678;
    localparam logic [31:0] CF = 32'hCAFEF00D;

    vec_t tv [NV];

    // Random-phase requester state and reference memory
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] padr [2];
    logic [31:0] pdat [2];
    int          pstart [2];
    logic [31:0] ref_mem [0:255];
    logic        a    [2];
    logic [31:0] rd   [2];

    initial begin
        // One row per cycle: inputs driven in that cycle, outputs expected in that cycle.
        //          rst   r0    w0    a0        d0  r1    w1    a1        d1  | ack0  ack1  rd0 rd1 madr      mwe   busy
        tv[0]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,  Z,  Z,        1'b0,1'b0};
        tv[1]  = '{1'b0,1'b1,1'b0,32'h12,   Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,  Z,  Z,        1'b0,1'b0};
        tv[2]  = '{1'b0,1'b1,1'b0,32'h12,   Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,  Z,  32'h10,   1'b0,1'b1};
        tv[3]  = '{1'b0,1'b1,1'b0,32'h12,   Z,  1'b0,1'b0,Z,        Z,  1'b1,1'b0,DB, Z,  32'h10,   1'b0,1'b1};
        tv[4]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, Z,  32'h10,   1'b0,1'b0};
        tv[5]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b1,32'h20,   W1, 1'b0,1'b0,DB, Z,  32'h10,   1'b0,1'b0};
        tv[6]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b1,32'h20,   W1, 1'b0,1'b0,DB, Z,  32'h20,   1'b1,1'b1};
        tv[7]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b1,32'h20,   W1, 1'b0,1'b1,DB, Z,  32'h20,   1'b0,1'b1};
        tv[8]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b0,32'h20,   Z,  1'b0,1'b0,DB, Z,  32'h20,   1'b0,1'b0};
        tv[9]  = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b0,32'h20,   Z,  1'b0,1'b0,DB, Z,  32'h20,   1'b0,1'b1};
        tv[10] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b0,32'h20,   Z,  1'b0,1'b1,DB, W1, 32'h20,   1'b0,1'b1};
        tv[11] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, W1, 32'h20,   1'b0,1'b0};
        tv[12] = '{1'b0,1'b1,1'b0,32'h10,   Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, W1, 32'h20,   1'b0,1'b0};
        tv[13] = '{1'b0,1'b1,1'b0,32'h30,   Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, W1, 32'h10,   1'b0,1'b1};
        tv[14] = '{1'b0,1'b1,1'b0,32'h30,   Z,  1'b0,1'b0,Z,        Z,  1'b1,1'b0,DB, W1, 32'h10,   1'b0,1'b1};
        tv[15] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, W1, 32'h10,   1'b0,1'b0};
        tv[16] = '{1'b0,1'b1,1'b0,32'h20,   Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,DB, W1, 32'h10,   1'b0,1'b0};
        tv[17] = '{1'b0,1'b1,1'b0,32'h20,   Z,  1'b1,1'b0,32'h10,   Z,  1'b0,1'b0,DB, W1, 32'h20,   1'b0,1'b1};
        tv[18] = '{1'b0,1'b1,1'b0,32'h20,   Z,  1'b1,1'b0,32'h10,   Z,  1'b1,1'b0,W1, W1, 32'h20,   1'b0,1'b1};
        tv[19] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b0,32'h10,   Z,  1'b0,1'b0,W1, W1, 32'h10,   1'b0,1'b1};
        tv[20] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b1,1'b0,32'h10,   Z,  1'b0,1'b1,W1, DB, 32'h10,   1'b0,1'b1};
        tv[21] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,W1, DB, 32'h10,   1'b0,1'b0};
        tv[22] = '{1'b0,1'b1,1'b1,32'h40,   CF, 1'b0,1'b0,Z,        Z,  1'b0,1'b0,W1, DB, 32'h10,   1'b0,1'b0};
        tv[23] = '{1'b1,1'b1,1'b1,32'h40,   CF, 1'b0,1'b0,Z,        Z,  1'b0,1'b0,W1, DB, 32'h40,   1'b0,1'b1};
        tv[24] = '{1'b0,1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,        Z,  1'b0,1'b0,Z,  Z,  Z,        1'b0,1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = DB;
        mem[32'h30 >> 2] = 32'h33333333;
        mem[32'h40 >> 2] = 32'h44444444;
        for (int i = 64; i < 80; i++) mem[i] = $urandom;

        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; adr0 = Z; wdata0 = Z;
        req1 = 1'b0; we1 = 1'b0; adr1 = Z; wdata1 = Z;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- directed cycle table ----------------
        for (int i = 0; i < NV; i++) begin
            rst  = tv[i].rst;
            req0 = tv[i].r0; we0 = tv[i].w0; adr0 = tv[i].a0; wdata0 = tv[i].d0;
            req1 = tv[i].r1; we1 = tv[i].w1; adr1 = tv[i].a1; wdata1 = tv[i].d1;
            #1;
            chk($sformatf("row%0d ack0", i),    {31'b0, ack0},   {31'b0, tv[i].e_ack0});
            chk($sformatf("row%0d ack1", i),    {31'b0, ack1},   {31'b0, tv[i].e_ack1});
            chk($sformatf("row%0d rdata0", i),  rdata0,          tv[i].e_rd0);
            chk($sformatf("row%0d rdata1", i),  rdata1,          tv[i].e_rd1);
            chk($sformatf("row%0d mem_adr", i), mem_adr,         tv[i].e_madr);
            chk($sformatf("row%0d mem_we", i),  {31'b0, mem_we}, {31'b0, tv[i].e_mwe});
            chk($sformatf("row%0d busy", i),    {31'b0, busy},   {31'b0, tv[i].e_busy});
            @(posedge clk);
            #1;
        end
        chk("write_committed_0x20", mem[32'h20 >> 2], W1);
        chk("reset_dropped_write_0x40", mem[32'h40 >> 2], 32'h44444444);

        // ---------------- simultaneous requests from reset ----------------
        // Both ports request continuously; the first tie goes to port 0, then
        // service alternates with an ack every second cycle.
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; adr1 = 32'h20;
        for (int c = 0; c <= 8; c++) begin
            #1;
            chk($sformatf("tie c%0d ack0", c), {31'b0, ack0}, {31'b0, (c % 4 == 2)});
            chk($sformatf("tie c%0d ack1", c), {31'b0, ack1}, {31'b0, (c % 4 == 0) && (c > 0)});
            if (ack0) chk($sformatf("tie c%0d rdata0", c), rdata0, DB);
            if (ack1) chk($sformatf("tie c%0d rdata1", c), rdata1, W1);
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; padr[p] = Z; pdat[p] = Z; pstart[p] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 3) != 0)) begin
                    pend[p]   = 1'b1;
                    pwe[p]    = $urandom_range(0, 1) == 1;
                    padr[p]   = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                    pdat[p]   = $urandom;
                    pstart[p] = cyc;
                end
            end
            req0 = pend[0]; we0 = pwe[0]; adr0 = padr[0]; wdata0 = pdat[0];
            req1 = pend[1]; we1 = pwe[1]; adr1 = padr[1]; wdata1 = pdat[1];
            #1;
            a[0] = ack0; a[1] = ack1; rd[0] = rdata0; rd[1] = rdata1;
            chk("rnd one_ack_at_most", {31'b0, ack0 & ack1}, Z);
            for (int p = 0; p < 2; p++) begin
                if (a[p]) begin
                    chk($sformatf("rnd ack%0d_has_request", p), {31'b0, pend[p]}, 32'h1);
                    chk_ok($sformatf("rnd ack%0d_latency", p),
                           (cyc - pstart[p] >= 2) && (cyc - pstart[p] <= 4), cyc - pstart[p], 2, 4);
                    if (pwe[p]) ref_mem[padr[p][9:2]] = pdat[p];
                    else chk($sformatf("rnd rdata%0d @%h", p, padr[p]), rd[p], ref_mem[padr[p][9:2]]);
                    pend[p] = 1'b0;
                end else if (pend[p] && (cyc - pstart[p] > 4)) begin
                    chk_ok($sformatf("rnd ack%0d_timeout", p), 1'b0, cyc - pstart[p], 2, 4);
                    pend[p] = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 64; i < 80; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
